uart_rx: RTL and testbench

8N1 UART receiver, the receive-side counterpart of the existing transmitter, using the same fractional-accumulator baud scheme. It oversamples the serial line at 16× the baud rate, majority-votes three samples per bit, and presents each received byte on a parallel port with a one-cycle strobe. It sits between the board RX pin and the CPU/debug logic. There is no backpressure: a consumer that misses a strobe loses the byte.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and helpers used by both the RX and TX sides
package uart_pkg;

  typedef enum logic [2:0] {
    rx_idle,
    rx_start,
    rx_data,
    rx_stop,
    rx_wait_high
  } UARTRxState;

  // round(oversample * freq_out * 2^acc_precision / freq_in), evaluated in 64 bits
  function automatic longint unsigned baud_increment(
    input longint unsigned freq_in,
    input longint unsigned freq_out,
    input int unsigned     acc_precision,
    input longint unsigned oversample
  );
    longint unsigned num;
    num = oversample * freq_out * (64'd1 << acc_precision);
    return (num + freq_in / 64'd2) / freq_in;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte output bundle of the UART receiver
interface uart_rx_if;
  logic       uart_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;

  modport master (
    input  uart_in,
    output data_out,
    output data_valid,
    output framing_error
  );

  modport slave (
    output uart_in,
    input  data_out,
    input  data_valid,
    input  framing_error
  );
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional accumulator tick generator; the carry-out is the tick
module uart_baud_gen #(
  parameter int unsigned     acc_precision = 16,
  parameter longint unsigned increment     = 1208
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [acc_precision:0] inc_w = increment[acc_precision:0];

  logic [acc_precision:0] r_acc;

  // The previous carry is dropped on each update, so the accumulator never overflows
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= {1'b0, r_acc[acc_precision-1:0]} + inc_w;
    end
  end

  assign o_tick = r_acc[acc_precision];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampled with 3-sample majority vote per bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned freq_in       = 50000000,
  parameter int unsigned freq_out      = 57600,
  parameter int unsigned acc_precision = 16
) (
  input  logic       clock,
  input  logic       reset,
  uart_rx_if.master  bus
);

  localparam longint unsigned increment =
    baud_increment(64'(freq_in), 64'(freq_out), acc_precision, 64'd16);

  logic       r_sync1;
  logic       r_sync2;
  logic       w_rx_s;
  logic       w_tick;
  logic       w_maj;

  UARTRxState r_state;
  logic [3:0] r_os_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic       r_s7;
  logic       r_s8;

  uart_baud_gen #(
    .acc_precision(acc_precision),
    .increment    (increment)
  ) u_baud_gen (
    .i_clock(clock),
    .i_reset(reset),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.uart_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;
  assign w_maj  = majority3(r_s7, r_s8, w_rx_s);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state            <= rx_idle;
      r_os_cnt           <= 4'd0;
      r_bit_idx          <= 3'd0;
      r_shift            <= 8'd0;
      r_s7               <= 1'b0;
      r_s8               <= 1'b0;
      bus.data_out       <= 8'd0;
      bus.data_valid     <= 1'b0;
      bus.framing_error  <= 1'b0;
    end else begin
      bus.data_valid    <= 1'b0;
      bus.framing_error <= 1'b0;
      if (w_tick) begin
        if (r_state == rx_start || r_state == rx_data || r_state == rx_stop) begin
          r_os_cnt <= r_os_cnt + 4'd1;
          if (r_os_cnt == 4'd7) r_s7 <= w_rx_s;
          if (r_os_cnt == 4'd8) r_s8 <= w_rx_s;
        end
        case (r_state)
          rx_idle: begin
            // The detecting tick is tick 0 of the start bit
            if (!w_rx_s) begin
              r_state  <= rx_start;
              r_os_cnt <= 4'd1;
            end
          end
          rx_start: begin
            if (r_os_cnt == 4'd9 && w_maj) begin
              r_state <= rx_idle;
            end else if (r_os_cnt == 4'd15) begin
              r_state   <= rx_data;
              r_bit_idx <= 3'd0;
            end
          end
          rx_data: begin
            if (r_os_cnt == 4'd9) begin
              r_shift <= {w_maj, r_shift[7:1]};
            end
            if (r_os_cnt == 4'd15) begin
              if (r_bit_idx == 3'd7) begin
                r_state <= rx_stop;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end
          end
          rx_stop: begin
            // Leaving at mid-stop-bit gives half a bit of slack to resync on the next start
            if (r_os_cnt == 4'd9) begin
              if (w_maj) begin
                bus.data_out   <= r_shift;
                bus.data_valid <= 1'b1;
                r_state        <= rx_idle;
              end else begin
                bus.framing_error <= 1'b1;
                r_state           <= rx_wait_high;
              end
            end
          end
          rx_wait_high: begin
            if (w_rx_s) r_state <= rx_idle;
          end
          default: r_state <= rx_idle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 32 clocks per bit
module tb_uart_rx;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         min_gap;
  } exp_t;

  logic clock;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;
  int   last_valid_cyc;
  exp_t exp_q[$];

  uart_rx_if bus();

  uart_rx #(
    .freq_in      (1843200),
    .freq_out     (57600),
    .acc_precision(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops an expectation for every strobe the DUT presents
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.data_valid && bus.framing_error)
        check("strobes_together", 32'd1, 32'd0);
      if (bus.data_valid || bus.framing_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {31'd0, bus.framing_error}, 32'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind", {31'd0, bus.framing_error}, {31'd0, e.is_err});
          check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
          if (e.min_gap > 0)
            check("valid_gap_ok", {31'd0, (cyc - last_valid_cyc) >= e.min_gap}, 32'd1);
        end
        if (bus.data_valid) last_valid_cyc = cyc;
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    bus.uart_in = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
    drive_bit(1'b0, 32);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 32);
    drive_bit(stop_v, stop_len);
  endtask

  task automatic expect_byte(input logic [7:0] d, input int gap);
    exp_t e;
    e.is_err = 1'b0; e.data = d; e.min_gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1; e.data = held; e.min_gap = 0;
    exp_q.push_back(e);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; last_valid_cyc = 0;
    reset = 1'b1;
    bus.uart_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_data_out", {24'd0, bus.data_out}, 32'd0);
    check("reset_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("reset_framing_error", {31'd0, bus.framing_error}, 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, 64);

    expect_byte(8'h55, 0);
    send_frame(8'h55, 1'b1, 32);
    drive_bit(1'b1, 64);

    expect_byte(8'hA3, 0);
    expect_byte(8'h00, 320);
    send_frame(8'hA3, 1'b1, 32);
    send_frame(8'h00, 1'b1, 32);
    drive_bit(1'b1, 64);

    drive_bit(1'b0, 8);
    drive_bit(1'b1, 64);

    expect_err(8'h00);
    send_frame(8'h7E, 1'b0, 64);
    drive_bit(1'b1, 64);
    expect_byte(8'h42, 0);
    send_frame(8'h42, 1'b1, 32);
    drive_bit(1'b1, 64);

    // 0xF0 with a one-tick high glitch around sample 8 of bit 1
    expect_byte(8'hF0, 0);
    drive_bit(1'b0, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 2);
    drive_bit(1'b0, 14);
    drive_bit(1'b0, 32);
    drive_bit(1'b0, 32);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b1, 64);

    drive_bit(1'b0, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b0, 16);
    bus.uart_in = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_data_out", {24'd0, bus.data_out}, 32'd0);
    check("midreset_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check("midreset_framing_error", {31'd0, bus.framing_error}, 32'd0);
    drive_bit(1'b1, 400);

    expect_byte(8'h81, 0);
    send_frame(8'h81, 1'b1, 32);
    drive_bit(1'b1, 64);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clock);
    check("all_expected_seen", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
